spi_frame_tx: RTL and testbench

//   SPI master, host side of the lamp frame link. Reads one frame (header + all

---
 rtl/spi_frame_tx.sv | 177 +++++++++++++++++
 tb/tb_spi_frame_tx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI master for the lamp frame link.
// Streams one header plus all channel words per start.
module spi_frame_tx #(
  parameter int c_ledboards = 2,
  parameter int c_bpc       = 12,
  parameter int c_max_time  = 1024,
  parameter int c_max_type  = 64,
  parameter int c_div       = 4,
  localparam int c_channels = c_ledboards * 32,
  localparam int c_time_w   = $clog2(c_max_time),
  localparam int c_type_w   = $clog2(c_max_type),
  localparam int c_addr_w   = $clog2(c_channels)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [c_time_w-1:0] i_time,
  input  logic [c_type_w-1:0] i_type,
  output logic [c_addr_w-1:0] o_addr,
  input  logic [c_bpc-1:0]    i_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_dck,
  output logic                o_cs,
  output logic                o_mosi
);

  localparam int c_hdr_w = c_time_w + c_type_w;
  localparam int c_sh_w  = (c_bpc > c_hdr_w) ? c_bpc : c_hdr_w;
  localparam int c_bit_w = $clog2(c_sh_w);
  localparam int c_cnt_w = $clog2(c_div);
  localparam logic [c_addr_w-1:0] c_last =
    c_addr_w'(c_channels - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HEADER,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [c_cnt_w-1:0]  cnt;
  logic [c_bit_w-1:0]  bcnt;
  logic [c_addr_w-1:0] wcnt;
  logic [c_sh_w-1:0]   sh;
  logic [c_sh_w-1:0]   hdr_al;
  logic [c_sh_w-1:0]   pf_al;
  logic [c_bpc-1:0]    pf;
  logic                pf_p1;
  logic                pf_p2;
  logic                tick;
  logic                bit_last;
  logic                word_last;
  logic                fall;

  // Half-period strobe, field/word end flags, MSB-aligned loads.
  always_comb begin
    tick      = (cnt == c_cnt_w'(c_div - 1));
    bit_last  = (bcnt == '0);
    word_last = (wcnt == c_last);
    fall      = tick && o_dck &&
                (state == S_HEADER || state == S_DATA);
    hdr_al    = '0;
    hdr_al[c_sh_w-1 -: c_hdr_w] = {i_time, i_type};
    pf_al     = '0;
    pf_al[c_sh_w-1 -: c_bpc] = pf;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state: SETUP is the low half of header bit 0.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (i_start) state_n = S_SETUP;
      S_SETUP:
        if (tick) state_n = S_HEADER;
      S_HEADER:
        if (fall && bit_last) state_n = S_DATA;
      S_DATA:
        if (fall && bit_last && word_last)
          state_n = S_HOLD;
      S_HOLD:
        if (tick) state_n = S_GAP;
      S_GAP:
        if (tick) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // Datapath: dck phases, shifter, word prefetch, pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      bcnt   <= '0;
      wcnt   <= '0;
      sh     <= '0;
      pf     <= '0;
      pf_p1  <= 1'b0;
      pf_p2  <= 1'b0;
      o_addr <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_dck  <= 1'b0;
      o_cs   <= 1'b1;
      o_mosi <= 1'b0;
    end else begin
      o_done <= 1'b0;
      pf_p1  <= 1'b0;
      pf_p2  <= pf_p1;
      if (pf_p2) pf <= i_data;
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            o_cs   <= 1'b0;
            o_addr <= '0;
            wcnt   <= '0;
            bcnt   <= c_bit_w'(c_hdr_w - 1);
            sh     <= hdr_al;
            o_mosi <= hdr_al[c_sh_w-1];
            pf_p1  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (tick) o_dck <= 1'b1;
        end
        S_HEADER, S_DATA: begin
          if (tick && !o_dck) begin
            o_dck <= 1'b1;
          end else if (fall) begin
            o_dck <= 1'b0;
            if (!bit_last) begin
              bcnt   <= bcnt - 1'b1;
              sh     <= sh << 1;
              o_mosi <= sh[c_sh_w-2];
            end else if (state == S_DATA && word_last) begin
              o_mosi <= 1'b0;
            end else begin
              bcnt   <= c_bit_w'(c_bpc - 1);
              sh     <= pf_al;
              o_mosi <= pf_al[c_sh_w-1];
              if (state == S_DATA) wcnt <= wcnt + 1'b1;
              if (o_addr != c_last) begin
                o_addr <= o_addr + 1'b1;
                pf_p1  <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            o_cs   <= 1'b1;
            o_done <= 1'b1;
          end
        end
        S_GAP: begin
          if (tick) o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: scoreboard bench for spi_frame_tx.
// Two instances: c_div=2 and c_div=4, one SPI monitor.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start2, start4;
  logic [9:0] t_time;
  logic [5:0] t_type;
  logic [5:0] addr2, addr4;
  logic [11:0] data2, data4;
  logic busy2, done2, dck2, cs2, mosi2;
  logic busy4, done4, dck4, cs4, mosi4;

  spi_frame_tx #(.c_div(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .i_time(t_time), .i_type(t_type), .o_addr(addr2),
    .i_data(data2), .o_busy(busy2), .o_done(done2),
    .o_dck(dck2), .o_cs(cs2), .o_mosi(mosi2));

  spi_frame_tx #(.c_div(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4),
    .i_time(t_time), .i_type(t_type), .o_addr(addr4),
    .i_data(data4), .o_busy(busy4), .o_done(done4),
    .o_dck(dck4), .o_cs(cs4), .o_mosi(mosi4));

  // Framebuffers: mem[n] = 12'h800 | n, one cycle read latency.
  always @(posedge clk) begin
    data2 <= 12'h800 | {6'd0, addr2};
    data4 <= 12'h800 | {6'd0, addr4};
  end

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  bit   sel = 1'b0;
  int   cur_div;
  logic m_dck, m_cs, m_mosi, m_busy, m_done;

  always_comb begin
    cur_div = sel ? 4 : 2;
    m_dck   = sel ? dck4  : dck2;
    m_cs    = sel ? cs4   : cs2;
    m_mosi  = sel ? mosi4 : mosi2;
    m_busy  = sel ? busy4 : busy2;
    m_done  = sel ? done4 : done2;
  end

  logic cap [0:1023];
  int   ncap = 0, nframes = 0, nstarts = 0, ndone = 0;
  int   viol_t = 0, viol_m = 0;
  int   run = 0, mrun = 0, hrun = 1000, last_gap = 0;
  logic p_dck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  bit   in_frame = 1'b0;

  // SPI monitor: captures bits on rising dck, checks phase lengths.
  always @(negedge clk) begin
    if (m_done) ndone++;
    if (!m_cs && p_cs) begin
      ncap = 0; run = 1; mrun = 1;
      in_frame = 1'b1; nstarts++; last_gap = hrun;
    end else if (!m_cs) begin
      if (m_dck && !p_dck) begin
        if (mrun < cur_div) viol_m++;
        if (ncap < 1024) cap[ncap] = m_mosi;
        ncap++;
      end
      if (m_dck != p_dck) begin
        if (run != cur_div) viol_t++;
        run = 1;
      end else run++;
      if (m_mosi != p_mosi) begin
        if (!(p_dck && !m_dck)) viol_m++;
        mrun = 1;
      end else mrun++;
    end
    if (m_cs && !p_cs && in_frame) begin
      if (rst_n && run != cur_div) viol_t++;
      in_frame = 1'b0; nframes++; hrun = 1;
    end else if (m_cs) hrun++;
    p_dck = m_dck; p_cs = m_cs; p_mosi = m_mosi;
  end

  function automatic logic [15:0] hdr_of();
    logic [15:0] h = '0;
    for (int i = 0; i < 16; i++) h = {h[14:0], cap[i]};
    return h;
  endfunction

  function automatic int good_words();
    int g = 0;
    for (int n = 0; n < 64; n++) begin
      logic [11:0] w = '0;
      for (int k = 0; k < 12; k++)
        w = {w[10:0], cap[16 + 12*n + k]};
      if (w === 12'(32'h800 | n)) g++;
    end
    return g;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    if (sel) start4 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_frames(input int tgt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (nframes >= tgt) begin ok = 1'b1; break; end
      @(posedge clk);
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (ncap >= n && !m_cs) begin ok = 1'b1; break; end
      @(posedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [10:0] v2, v4;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    v2 = {cs2, dck2, mosi2, busy2, done2, addr2};
    v4 = {cs4, dck4, mosi4, busy4, done4, addr4};
    tests++;
    if (v2 !== 11'b10000_000000) begin
      fails++;
      $display("FAIL reset_div2 got %b want %b", v2, 11'b10000_000000);
    end
    tests++;
    if (v4 !== 11'b10000_000000) begin
      fails++;
      $display("FAIL reset_div4 got %b want %b", v4, 11'b10000_000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame();
    int b, d0, ok_i;
    bit ok;
    logic [15:0] e;
    sel = 1'b0; t_time = 10'h2A5; t_type = 6'h15;
    b = nframes; d0 = ndone; viol_t = 0; viol_m = 0;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    wait_frames(b + 1, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL frame_timeout got 0 want 1");
    end
    e = exp_q.pop_front();
    tests++;
    if (hdr_of() !== e) begin
      fails++; $display("FAIL frame_hdr got %h want %h", hdr_of(), e);
    end
    tests++;
    if (ncap !== 784) begin
      fails++; $display("FAIL frame_rises got %0d want 784", ncap);
    end
    tests++;
    if (good_words() !== 64) begin
      fails++;
      $display("FAIL frame_words got %0d want 64", good_words());
    end
    wait_idle(ok);
    ok_i = ok ? 1 : 0;
    tests++;
    if (ok_i !== 1) begin
      fails++; $display("FAIL frame_busy_end got busy want idle");
    end
    tests++;
    if (ndone - d0 !== 1) begin
      fails++; $display("FAIL frame_done got %0d want 1", ndone - d0);
    end
    tests++;
    if (viol_t + viol_m !== 0) begin
      fails++;
      $display("FAIL frame_timing got %0d/%0d want 0/0", viol_t, viol_m);
    end
  endtask

  task automatic test_timing();
    int b;
    bit ok;
    logic [15:0] e;
    sel = 1'b1; t_time = 10'h3C1; t_type = 6'h2A;
    b = nframes; viol_t = 0; viol_m = 0;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    tests++;
    if (m_busy !== 1'b1) begin
      fails++; $display("FAIL timing_busy got %b want 1", m_busy);
    end
    wait_frames(b + 1, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || hdr_of() !== e) begin
      fails++; $display("FAIL timing_hdr got %h want %h", hdr_of(), e);
    end
    tests++;
    if (viol_t !== 0) begin
      fails++; $display("FAIL timing_dck got %0d bad phases want 0", viol_t);
    end
    tests++;
    if (viol_m !== 0) begin
      fails++; $display("FAIL timing_mosi got %0d bad changes want 0", viol_m);
    end
    tests++;
    if (ncap !== 784 || good_words() !== 64) begin
      fails++;
      $display("FAIL timing_data got %0d bits/%0d words want 784/64",
               ncap, good_words());
    end
    wait_idle(ok);
  endtask

  task automatic test_busy_start();
    int b, s0, d0;
    bit ok;
    logic [15:0] e;
    sel = 1'b1; t_time = 10'h155; t_type = 6'h3F;
    b = nframes; s0 = nstarts; d0 = ndone;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    wait_bits(5, ok);
    pulse_start();
    wait_bits(216, ok);
    pulse_start();
    wait_frames(b + 1, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || hdr_of() !== e || good_words() !== 64) begin
      fails++; $display("FAIL busy_frame got %h want %h", hdr_of(), e);
    end
    repeat (200) @(posedge clk);
    tests++;
    if (nstarts - s0 !== 1) begin
      fails++; $display("FAIL busy_ignored got %0d frames want 1", nstarts - s0);
    end
    tests++;
    if (ndone - d0 !== 1) begin
      fails++; $display("FAIL busy_done got %0d want 1", ndone - d0);
    end
  endtask

  task automatic test_back_to_back();
    int b, s0, d0;
    bit ok;
    logic [15:0] e;
    sel = 1'b1; t_time = 10'h0F0; t_type = 6'h0C;
    b = nframes; s0 = nstarts; d0 = ndone;
    exp_q.push_back({t_time, t_type});
    exp_q.push_back({t_time, t_type});
    @(posedge clk); #1;
    start4 = 1'b1;
    wait_frames(b + 1, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || hdr_of() !== e || ncap !== 784) begin
      fails++; $display("FAIL b2b_first got %h/%0d want %h/784", hdr_of(), ncap, e);
    end
    for (int i = 0; i < 100; i++) begin
      if (nstarts - s0 >= 2) break;
      @(posedge clk);
    end
    #1;
    start4 = 1'b0;
    wait_frames(b + 2, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || hdr_of() !== e || good_words() !== 64) begin
      fails++; $display("FAIL b2b_second got %h want %h", hdr_of(), e);
    end
    tests++;
    if (last_gap < 4) begin
      fails++; $display("FAIL b2b_gap got %0d want >=4", last_gap);
    end
    repeat (50) @(posedge clk);
    tests++;
    if (nstarts - s0 !== 2 || ndone - d0 !== 2) begin
      fails++;
      $display("FAIL b2b_count got %0d/%0d want 2/2", nstarts - s0, ndone - d0);
    end
  endtask

  task automatic test_reset_midframe();
    int b;
    bit ok;
    logic [15:0] e;
    sel = 1'b1; t_time = 10'h2A5; t_type = 6'h15;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    wait_bits(316, ok);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (!ok || cs4 !== 1'b1 || dck4 !== 1'b0) begin
      fails++; $display("FAIL midreset_cs got cs=%b dck=%b want 1/0", cs4, dck4);
    end
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    b = nframes; viol_t = 0; viol_m = 0;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    wait_frames(b + 1, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok || hdr_of() !== e) begin
      fails++; $display("FAIL midreset_hdr got %h want %h", hdr_of(), e);
    end
    tests++;
    if (ncap !== 784 || good_words() !== 64 || viol_t + viol_m !== 0) begin
      fails++;
      $display("FAIL midreset_frame got %0d bits/%0d words/%0d viol want 784/64/0",
               ncap, good_words(), viol_t + viol_m);
    end
    wait_idle(ok);
  endtask

  task automatic test_loopback();
    int b, d0, nwr;
    bit ok;
    logic [15:0] h;
    sel = 1'b0; t_time = 10'h2A5; t_type = 6'h15;
    b = nframes; d0 = ndone;
    exp_q.push_back({t_time, t_type});
    pulse_start();
    wait_frames(b + 1, ok);
    void'(exp_q.pop_front());
    h = hdr_of();
    nwr = ok ? good_words() : 0;
    tests++;
    if (h[15:6] !== 10'h2A5) begin
      fails++; $display("FAIL rx_time got %h want 2a5", h[15:6]);
    end
    tests++;
    if (h[5:0] !== 6'h15) begin
      fails++; $display("FAIL rx_type got %h want 15", h[5:0]);
    end
    tests++;
    if (nwr !== 64) begin
      fails++; $display("FAIL rx_writes got %0d want 64", nwr);
    end
    wait_idle(ok);
    tests++;
    if (ndone - d0 !== 1) begin
      fails++; $display("FAIL rx_ready got %0d want 1", ndone - d0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0;
    t_time = '0; t_type = '0;
    #22 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_frame();
    test_reset();
    test_timing();
    test_busy_start();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
